compress_bit_packer: RTL and testbench

- Downstream neighbour of compress_unit.
- Consumes variable-length compressed codes, one per handshake: a code value plus its bit length.
- Concatenates the codes into a dense LSB-first bitstream and emits 32-bit words to the memory/stream writer.
- Supports an end-of-stream flush that emits the zero-padded residual word tagged with out_last.

---
 rtl/compress_bit_packer.sv | 171 +++++++++++++++++
 tb/tb_compress_bit_packer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compress_bit_packer.sv
// compress_bit_packer
//
// Packs variable-length codes (value + bit length) into a dense LSB-first
// bitstream and emits 32-bit words. An end-of-stream flush emits the
// zero-padded residual word tagged with out_last. If nothing is buffered,
// the flush emits an empty terminator word instead.
//
// Optional build macro: PACKER_BIT_COUNT_EN adds the bit_count output.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   enable     global stall; low freezes all state, gates in_ready/out_valid
//   in_valid   code present on data_in/in_len
//   in_ready   packer accepts a code this cycle
//   data_in    right-justified code value (bits at/above in_len ignored)
//   in_len     code length 0..32; larger values are dropped and flag error
//   flush      end-of-stream request pulse
//   out_valid  data_out holds a word
//   out_ready  consumer accepts the word
//   data_out   packed word, first code bit at bit 0
//   out_bits   valid bits in data_out (32, residual count, or 0)
//   out_last   data_out is the final word of the stream
//   status     00 idle, 01 holding bits, 10 flushing, 11 sticky error
//   bit_count  (PACKER_BIT_COUNT_EN only) code bits accepted since reset
//              or since the last out_last handshake
//
// State   | meaning
// --------+-----------------------------------------------------------
// PACK    | accepting codes, emitting full 32-bit words
// FLUSH   | draining remaining words, last one tagged out_last
module compress_bit_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LEN_WIDTH-1:0]  in_len,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LEN_WIDTH-1:0]  out_bits,
  output logic                  out_last,
  output logic [1:0]            status
`ifdef PACKER_BIT_COUNT_EN
  ,
  output logic [31:0]           bit_count
`endif
);

  localparam logic [0:0] ST_PACK  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [63:0] r_buf;
  logic [6:0]  r_count;
  logic [0:0]  r_state;
  logic        r_error;

  logic        w_full;
  logic        w_tail;
  logic        w_accept;
  logic        w_legal;
  logic        w_drain;
  logic [31:0] w_mask;
  logic [63:0] w_code;
  logic [63:0] w_buf_shift;
  logic [6:0]  w_count_shift;
  logic [63:0] w_buf_pack;
  logic [6:0]  w_count_pack;

  assign w_full    = (r_count >= 7'd32);
  // In FLUSH, the word that empties the buffer is the final one.
  assign w_tail    = (r_state == ST_FLUSH) && (r_count <= 7'd32);

  assign in_ready  = enable && (r_state == ST_PACK) && (r_count <= 7'd32);
  assign out_valid = enable && ((r_state == ST_FLUSH) || w_full);

  assign w_accept  = in_valid && in_ready;
  assign w_legal   = (in_len <= 6'd32);
  assign w_drain   = out_valid && out_ready;

  assign w_mask    = (in_len >= 6'd32) ? 32'hFFFF_FFFF
                                       : ((32'd1 << in_len) - 32'd1);
  assign w_code    = {32'd0, data_in & w_mask};

  // The drain happens before the accept. A code accepted in the same cycle
  // therefore lands relative to the already-shifted buffer.
  assign w_buf_shift   = w_drain ? {32'd0, r_buf[63:32]} : r_buf;
  assign w_count_shift = w_drain ? (r_count - 7'd32) : r_count;
  assign w_buf_pack    = w_buf_shift | (w_code << w_count_shift);
  assign w_count_pack  = w_count_shift + {1'b0, in_len};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf   <= '0;
      r_count <= '0;
      r_state <= ST_PACK;
      r_error <= 1'b0;
    end else if (enable) begin
      case (r_state)
        ST_PACK: begin
          if (w_accept && w_legal) begin
            r_buf   <= w_buf_pack;
            r_count <= w_count_pack;
          end else begin
            r_buf   <= w_buf_shift;
            r_count <= w_count_shift;
          end
          if (w_accept && !w_legal) begin
            r_error <= 1'b1;
          end
          if (flush) begin
            r_state <= ST_FLUSH;
          end
        end
        default: begin
          if (w_drain) begin
            if (w_tail) begin
              r_buf   <= '0;
              r_count <= '0;
              r_state <= ST_PACK;
            end else begin
              r_buf   <= w_buf_shift;
              r_count <= w_count_shift;
            end
          end
        end
      endcase
    end
  end

`ifdef PACKER_BIT_COUNT_EN
  logic [31:0] r_bit_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_count <= '0;
    end else if (enable) begin
      if (w_drain && w_tail) begin
        r_bit_count <= '0;
      end else if (w_accept && w_legal) begin
        r_bit_count <= r_bit_count + {26'd0, in_len};
      end
    end
  end

  assign bit_count = r_bit_count;
`endif

  // Bits above r_count are always zero, so the residual word needs no masking.
  assign data_out = r_buf[31:0];
  assign out_bits = w_full ? 6'd32 : r_count[5:0];
  assign out_last = w_tail;

  always_comb begin
    status = 2'b00;
    if (r_error) begin
      status = 2'b11;
    end else if (r_state == ST_FLUSH) begin
      status = 2'b10;
    end else if (r_count != 7'd0) begin
      status = 2'b01;
    end
  end

endmodule

// File: tb/tb_compress_bit_packer.sv
module tb_compress_bit_packer;

  logic        clk = 1'b0;
  logic        reset, enable, in_valid, flush, out_ready;
  logic [31:0] data_in;
  logic [5:0]  in_len;
  logic        in_ready, out_valid, out_last;
  logic [31:0] data_out;
  logic [5:0]  out_bits;
  logic [1:0]  status;
`ifdef PACKER_BIT_COUNT_EN
  logic [31:0] bit_count;
`endif

  compress_bit_packer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .in_len(in_len), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_bits(out_bits), .out_last(out_last),
    .status(status)
`ifdef PACKER_BIT_COUNT_EN
    , .bit_count(bit_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // Reference model: a plain queue of stream bits plus flush/error flags.
  bit          m_q[$];
  bit          m_flush  = 0;
  bit          m_err    = 0;
  bit          m_active = 0;
  logic [31:0] m_bc     = 0;
  logic [38:0] cap[$];     // {last, bits, data} of every accepted word

  int          m_sz;
  bit          e_ir, e_ov, e_last, pre_flush, m_drain, m_acc;
  logic [31:0] e_w;
  logic [5:0]  e_bits;
  logic [1:0]  e_st;

  always @(negedge clk) begin
    m_sz      = m_q.size();
    e_ir      = enable && !m_flush && (m_sz <= 32);
    e_ov      = enable && (m_flush || (m_sz >= 32));
    e_last    = m_flush && (m_sz <= 32);
    e_bits    = (m_sz >= 32) ? 6'd32 : 6'(m_sz);
    e_st      = m_err ? 2'b11 : (m_flush ? 2'b10 : ((m_sz != 0) ? 2'b01 : 2'b00));
    e_w       = '0;
    for (int i = 0; i < 32; i++) if (i < m_sz) e_w[i] = m_q[i];
    if (m_active) begin
      check("in_ready", in_ready, e_ir);
      check("out_valid", out_valid, e_ov);
      check("status", status, e_st);
`ifdef PACKER_BIT_COUNT_EN
      check("bit_count", bit_count, m_bc);
`endif
      if (e_ov) begin
        check("data_out", data_out, e_w);
        check("out_bits", out_bits, e_bits);
        check("out_last", out_last, e_last);
      end
      if (out_valid && out_ready) cap.push_back({out_last, out_bits, data_out});
    end
    if (reset) begin
      m_q.delete();
      m_flush  = 0;
      m_err    = 0;
      m_bc     = 0;
      m_active = 1;
    end else if (m_active && enable) begin
      pre_flush = m_flush;
      m_drain   = e_ov && out_ready;
      m_acc     = e_ir && in_valid;
      if (m_drain && e_last) begin
        m_q.delete();
        m_flush = 0;
        m_bc    = 0;
      end else if (m_drain) begin
        repeat (32) void'(m_q.pop_front());
      end
      if (m_acc) begin
        if (in_len <= 6'd32) begin
          for (int i = 0; i < 32; i++) if (i < int'(in_len)) m_q.push_back(data_in[i]);
          m_bc = m_bc + 32'(in_len);
        end else begin
          m_err = 1;
        end
      end
      if (!pre_flush && flush) m_flush = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [5:0] l);
    bit done;
    done     = 0;
    in_valid = 1; data_in = d; in_len = l;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      step();
    end
    in_valid = 0;
    if (!done) timeout("send");
  endtask

  task automatic pulse_flush();
    flush = 1;
    step();
    flush = 0;
  endtask

  task automatic wait_words(input int n);
    bit got;
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (cap.size() >= n) got = 1;
      else step();
    end
    if (!got) timeout("wait_words");
  endtask

  task automatic check_word(input string name, input int idx, input logic [31:0] d,
                            input logic [5:0] b, input logic l);
    if (cap.size() > idx) begin
      check({name, "_data"}, cap[idx][31:0], d);
      check({name, "_bits"}, cap[idx][37:32], b);
      check({name, "_last"}, cap[idx][38], l);
    end else begin
      timeout({name, "_missing"});
    end
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    reset = 1; enable = 1; in_valid = 0; flush = 0; out_ready = 0;
    data_in = '0; in_len = '0;
    repeat (2) step();
    reset = 0;

    // Reset values
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_status", status, 2'b00);
    check("rst_out_bits", out_bits, 6'd0);
    check("rst_data_out", data_out, 32'd0);
    step();

    // Two codes then flush
    out_ready = 1;
    cap.delete();
    send(32'h5, 6'd3);
    @(negedge clk); check("t1_status_pack", status, 2'b01); step();
    send(32'h1F, 6'd5);
    pulse_flush();
    @(negedge clk); check("t1_status_flush", status, 2'b10); step();
    wait_words(1);
    check_word("t1", 0, 32'h0000_00FD, 6'd8, 1'b1);
    @(negedge clk); check("t1_status_idle", status, 2'b00); step();

    // Four 16-bit codes back-to-back
    cap.delete();
    send(32'hAAAA, 6'd16);
    send(32'hBBBB, 6'd16);
    send(32'hCCCC, 6'd16);
    send(32'hDDDD, 6'd16);
    wait_words(2);
    check_word("t2w0", 0, 32'hBBBB_AAAA, 6'd32, 1'b0);
    check_word("t2w1", 1, 32'hDDDD_CCCC, 6'd32, 1'b0);
    step();
    @(negedge clk); check("t2_status_idle", status, 2'b00); step();

    // Backpressure
    cap.delete();
    out_ready = 0;
    send(32'h1111_1111, 6'd32);
    send(32'h2222_2222, 6'd32);
    in_valid = 1; data_in = 32'h3333_3333; in_len = 6'd32;
    repeat (3) begin
      @(negedge clk);
      check("t3_in_ready_blocked", in_ready, 1'b0);
      check("t3_held_data", data_out, 32'h1111_1111);
      step();
    end
    out_ready = 1;
    send(32'h3333_3333, 6'd32);
    wait_words(3);
    check_word("t3w0", 0, 32'h1111_1111, 6'd32, 1'b0);
    check_word("t3w1", 1, 32'h2222_2222, 6'd32, 1'b0);
    check_word("t3w2", 2, 32'h3333_3333, 6'd32, 1'b0);
    @(negedge clk); check("t3_status_idle", status, 2'b00); step();

    // Flush with nothing buffered
    cap.delete();
    pulse_flush();
    wait_words(1);
    check_word("t4", 0, 32'd0, 6'd0, 1'b1);

    // Illegal length
    cap.delete();
    send(32'hFFFF_FFFF, 6'd40);
    @(negedge clk); check("t5_status_err", status, 2'b11); step();
    send(32'h3, 6'd2);
`ifdef PACKER_BIT_COUNT_EN
    @(negedge clk); check("t5_bit_count", bit_count, 32'd2); step();
`endif
    pulse_flush();
    wait_words(1);
    check_word("t5", 0, 32'h0000_0003, 6'd2, 1'b1);
    @(negedge clk); check("t5_status_sticky", status, 2'b11); step();

    // Reset mid-flush
    do_reset();
    cap.delete();
    out_ready = 0;
    send(32'hAAAA_AAAA, 6'd32);
    send(32'hFF, 6'd8);
    pulse_flush();
    out_ready = 1;
    step();
    out_ready = 0;
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    check("t6_rst_out_valid", out_valid, 1'b0);
    check("t6_rst_status", status, 2'b00);
    check("t6_rst_in_ready", in_ready, 1'b1);
    check("t6_rst_last", out_last, 1'b0);
    check("t6_rst_bits", out_bits, 6'd0);
    step();
    check_word("t6_first", 0, 32'hAAAA_AAAA, 6'd32, 1'b0);
    check("t6_one_word", cap.size(), 1);
    cap.delete();
    out_ready = 1;
    repeat (5) step();
    check("t6_no_words", cap.size(), 0);
    send(32'h7, 6'd3);
    pulse_flush();
    wait_words(1);
    check_word("t6", 0, 32'h0000_0007, 6'd3, 1'b1);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      enable    = ($urandom % 8) != 0;
      in_valid  = $urandom % 2;
      in_len    = (($urandom % 16) == 0) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 32));
      data_in   = $urandom;
      flush     = ($urandom % 40) == 0;
      out_ready = ($urandom % 4) != 0;
      reset     = ($urandom % 500) == 0;
      step();
    end
    enable = 1; in_valid = 0; flush = 0; reset = 0; out_ready = 1;
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
